// File: rtl/signal_monitor_pkg.sv
// Shared definitions for the signal conflict monitor: lamp encodings,
// fault codes, FSM states and packed all-red / all-yellow lamp patterns.
package signal_monitor_pkg;

  typedef enum logic [1:0] {
    LIGHT_RED     = 2'b00,
    LIGHT_YELLOW  = 2'b01,
    LIGHT_GREEN   = 2'b10,
    LIGHT_ILLEGAL = 2'b11
  } light_t;

  // Fault codes; a lower non-zero code wins when several fire together
  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_ILLEGAL      = 3'd1;
  localparam logic [2:0] FC_MULTI_GREEN  = 3'd2;
  localparam logic [2:0] FC_GREEN_TO_RED = 3'd3;
  localparam logic [2:0] FC_SHORT_YELLOW = 3'd4;

  typedef enum logic [1:0] {
    ST_MONITOR = 2'd0,
    ST_FAULT   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  // Four approaches packed {west, south, east, north}
  localparam logic [7:0] LAMPS_ALL_RED    = 8'h00;
  localparam logic [7:0] LAMPS_ALL_YELLOW = 8'h55;

endpackage

// File: rtl/scm_approach_check.sv
// Per-approach transition checker: keeps the previous light code and flags
// a direct green->red change. When SCM_YELLOW_CHECK_EN is defined it also
// times each yellow phase and flags a yellow->red change that came too early.
module scm_approach_check
  import signal_monitor_pkg::*;
#(
  parameter int MIN_YEL_CYC = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] code_in,
  output logic       green_to_red,
  output logic       short_yellow
);

  logic [1:0] prev_reg;

  // Previous-cycle light code, tracked in every monitor state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_reg <= LIGHT_RED;
    else        prev_reg <= code_in;
  end

  assign green_to_red = (prev_reg == LIGHT_GREEN) && (code_in == LIGHT_RED);

`ifdef SCM_YELLOW_CHECK_EN
  localparam int CW = $clog2(MIN_YEL_CYC + 1);
  localparam logic [CW-1:0] YEL_MAX = CW'(MIN_YEL_CYC);

  logic [CW-1:0] yel_cnt_reg;

  // Count yellow cycles; held at zero outside yellow so each yellow starts fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        yel_cnt_reg <= '0;
    else if (code_in != LIGHT_YELLOW)  yel_cnt_reg <= '0;
    else if (yel_cnt_reg != YEL_MAX)   yel_cnt_reg <= yel_cnt_reg + CW'(1);
  end

  // Only yellow->red is timed; yellow->green and yellow->yellow are legal
  assign short_yellow = (prev_reg == LIGHT_YELLOW) && (code_in == LIGHT_RED) &&
                        (yel_cnt_reg < YEL_MAX);
`else
  assign short_yellow = 1'b0;
`endif

endmodule

// File: rtl/signal_conflict_monitor.sv
// Signal conflict monitor: passes sequencer light codes to the lamps with
// one cycle of latency, and on any conflict flashes red/yellow until
// acknowledged, then holds all-red before resuming. Optional yellow-timing
// check is built in when SCM_YELLOW_CHECK_EN is defined.
module signal_conflict_monitor
  import signal_monitor_pkg::*;
#(
  parameter int MIN_YEL_CYC = 50000000,
  parameter int FLASH_CYC   = 25000000,
  parameter int RECOVER_CYC = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] north_in,
  input  logic [1:0] east_in,
  input  logic [1:0] south_in,
  input  logic [1:0] west_in,
  input  logic       clear_fault,
  output logic [1:0] north_out,
  output logic [1:0] east_out,
  output logic [1:0] south_out,
  output logic [1:0] west_out,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       mon_active
);

  localparam int FCW = $clog2(FLASH_CYC + 1);
  localparam int RCW = $clog2(RECOVER_CYC + 1);
  localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_CYC - 1);
  localparam logic [RCW-1:0] REC_LAST   = RCW'(RECOVER_CYC - 1);

  logic [3:0][1:0] light_in;
  logic [3:0]      g2r;
  logic [3:0]      short_yel;
  logic [2:0]      viol_code;
  state_t          state_reg, state_next;
  logic [2:0]      fault_code_reg;
  logic [RCW-1:0]  rec_cnt_reg;
  logic [FCW-1:0]  flash_cnt_reg;
  logic            flash_phase_reg;
  logic [7:0]      lamps_reg;

  assign light_in = {west_in, south_in, east_in, north_in};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_approach
      scm_approach_check #(
        .MIN_YEL_CYC(MIN_YEL_CYC)
      ) u_check (
        .clk         (clk),
        .rst_n       (rst_n),
        .code_in     (light_in[gi]),
        .green_to_red(g2r[gi]),
        .short_yellow(short_yel[gi])
      );
    end
  endgenerate

  // Classify the current inputs; code 1 outranks 2, 2 outranks 3, 3 outranks 4
  always_comb begin
    logic       any_illegal;
    logic [2:0] green_cnt;
    any_illegal = 1'b0;
    green_cnt   = 3'd0;
    viol_code   = FC_NONE;
    for (int i = 0; i < 4; i++) begin
      if (light_in[i] == LIGHT_ILLEGAL) any_illegal = 1'b1;
      if (light_in[i] == LIGHT_GREEN)   green_cnt = green_cnt + 3'd1;
    end
    if (any_illegal)           viol_code = FC_ILLEGAL;
    else if (green_cnt >= 3'd2) viol_code = FC_MULTI_GREEN;
    else if (|g2r)             viol_code = FC_GREEN_TO_RED;
    else if (|short_yel)       viol_code = FC_SHORT_YELLOW;
  end

  // Next-state logic; a violation in RECOVER beats the recover timeout
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_MONITOR: if (viol_code != FC_NONE) state_next = ST_FAULT;
      ST_FAULT:   if (clear_fault) state_next = ST_RECOVER;
      ST_RECOVER: begin
        if (viol_code != FC_NONE)     state_next = ST_FAULT;
        else if (rec_cnt_reg == REC_LAST) state_next = ST_MONITOR;
      end
      default:    state_next = ST_RECOVER;
    endcase
  end

  // State register and fault code: latch on FAULT entry, zero on acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_RECOVER;
      fault_code_reg <= FC_NONE;
    end else begin
      state_reg <= state_next;
      if ((state_reg != ST_FAULT) && (state_next == ST_FAULT))
        fault_code_reg <= viol_code;
      else if ((state_reg == ST_FAULT) && (state_next == ST_RECOVER))
        fault_code_reg <= FC_NONE;
    end
  end

  // All-red hold timer, restarted every time RECOVER is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rec_cnt_reg <= '0;
    else if ((state_reg == ST_RECOVER) && (state_next == ST_RECOVER))
      rec_cnt_reg <= rec_cnt_reg + RCW'(1);
    else
      rec_cnt_reg <= '0;
  end

  // Lamp drive chosen from the upcoming state so a bad pattern never shows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lamps_reg       <= LAMPS_ALL_RED;
      flash_cnt_reg   <= '0;
      flash_phase_reg <= 1'b0;
    end else begin
      case (state_next)
        ST_MONITOR: begin
          lamps_reg       <= light_in;
          flash_cnt_reg   <= '0;
          flash_phase_reg <= 1'b0;
        end
        ST_FAULT: begin
          if (state_reg != ST_FAULT) begin
            lamps_reg       <= LAMPS_ALL_RED;
            flash_cnt_reg   <= '0;
            flash_phase_reg <= 1'b0;
          end else if (flash_cnt_reg == FLASH_LAST) begin
            flash_cnt_reg   <= '0;
            flash_phase_reg <= ~flash_phase_reg;
            lamps_reg       <= flash_phase_reg ? LAMPS_ALL_RED : LAMPS_ALL_YELLOW;
          end else begin
            flash_cnt_reg <= flash_cnt_reg + FCW'(1);
          end
        end
        default: begin
          lamps_reg       <= LAMPS_ALL_RED;
          flash_cnt_reg   <= '0;
          flash_phase_reg <= 1'b0;
        end
      endcase
    end
  end

  assign {west_out, south_out, east_out, north_out} = lamps_reg;
  assign fault      = (state_reg == ST_FAULT);
  assign mon_active = (state_reg == ST_MONITOR);
  assign fault_code = fault_code_reg;

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Bench for signal_conflict_monitor with MIN_YEL_CYC=4, FLASH_CYC=3,
// RECOVER_CYC=5. Expectations follow SCM_YELLOW_CHECK_EN when defined.
module tb_signal_conflict_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] north_in, east_in, south_in, west_in;
  logic       clear_fault;
  logic [1:0] north_out, east_out, south_out, west_out;
  logic       fault;
  logic [2:0] fault_code;
  logic       mon_active;

  signal_conflict_monitor #(
    .MIN_YEL_CYC(4),
    .FLASH_CYC  (3),
    .RECOVER_CYC(5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .north_in   (north_in),
    .east_in    (east_in),
    .south_in   (south_in),
    .west_in    (west_in),
    .clear_fault(clear_fault),
    .north_out  (north_out),
    .east_out   (east_out),
    .south_out  (south_out),
    .west_out   (west_out),
    .fault      (fault),
    .fault_code (fault_code),
    .mon_active (mon_active)
  );

  always #5 clk = ~clk;

  // Inputs and lamps packed {north, east, south, west}
  typedef struct {
    logic [7:0] in;
    logic       clr;
    logic [7:0] lamps;
    logic       flt;
    logic [2:0] code;
    logic       mon;
  } vec_t;

  typedef struct {
    logic [7:0] lamps;
    logic       flt;
    logic [2:0] code;
    logic       mon;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  function automatic vec_t mk(input logic [7:0] in, input logic clr, input logic [7:0] lamps,
                              input logic flt, input logic [2:0] code, input logic mon);
    vec_t v;
    v.in = in; v.clr = clr; v.lamps = lamps; v.flt = flt; v.code = code; v.mon = mon;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lamps_now();
    return {north_out, east_out, south_out, west_out};
  endfunction

  // Drive one vector, queue its expectation, compare after the next edge
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    north_in    = v.in[7:6];
    east_in     = v.in[5:4];
    south_in    = v.in[3:2];
    west_in     = v.in[1:0];
    clear_fault = v.clr;
    e.lamps = v.lamps; e.flt = v.flt; e.code = v.code; e.mon = v.mon;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    $display("%s: in=%b clr=%b lamps=%b fault=%b code=%0d mon=%b",
             tag, v.in, v.clr, lamps_now(), fault, fault_code, mon_active);
    check({tag, " lamps"}, lamps_now(), e.lamps);
    check({tag, " fault"}, {7'd0, fault}, {7'd0, e.flt});
    check({tag, " code"},  {5'd0, fault_code}, {5'd0, e.code});
    check({tag, " mon"},   {7'd0, mon_active}, {7'd0, e.mon});
  endtask

  task automatic run(input string name);
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("%s[%0d]", name, i));
    tbl.delete();
  endtask

  // Acknowledge the fault (inputs red) and sit out the 5-cycle all-red hold
  task automatic clear_and_recover();
    tbl.push_back(mk(8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1));
    run("recover");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    north_in = 2'b00; east_in = 2'b00; south_in = 2'b00; west_in = 2'b00;
    clear_fault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset lamps", lamps_now(), 8'h00);
    check("reset fault", {7'd0, fault}, 8'd0);
    check("reset code",  {5'd0, fault_code}, 8'd0);
    check("reset mon",   {7'd0, mon_active}, 8'd0);
    rst_n = 1'b1;

    // Start-up hold, pass-through, double green, flash pattern
    for (int i = 0; i < 4; i++) tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(8'h00,         1'b0, 8'h00,         1'b0, 3'd0, 1'b1));
    tbl.push_back(mk(8'b10_00_00_00, 1'b0, 8'b10_00_00_00, 1'b0, 3'd0, 1'b1));
    tbl.push_back(mk(8'b10_10_00_00, 1'b0, 8'h00,         1'b1, 3'd2, 1'b0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b1, 3'd2, 1'b0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b1, 3'd2, 1'b0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(8'h00, 1'b0, 8'h55, 1'b1, 3'd2, 1'b0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b1, 3'd2, 1'b0));
    run("startup");
    clear_and_recover();

    // Green straight to red; clear_fault in MONITOR is ignored
    tbl.push_back(mk(8'b10_00_00_00, 1'b1, 8'b10_00_00_00, 1'b0, 3'd0, 1'b1));
    tbl.push_back(mk(8'h00,         1'b0, 8'h00,         1'b1, 3'd3, 1'b0));
    run("g2r");
    clear_and_recover();

    // Legal sequence: yellow->green allowed, full 4-cycle yellow then red
    tbl.push_back(mk(8'b10_00_00_00, 1'b0, 8'b10_00_00_00, 1'b0, 3'd0, 1'b1));
    tbl.push_back(mk(8'b01_00_00_00, 1'b0, 8'b01_00_00_00, 1'b0, 3'd0, 1'b1));
    tbl.push_back(mk(8'b10_00_00_00, 1'b0, 8'b10_00_00_00, 1'b0, 3'd0, 1'b1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(8'b01_00_00_00, 1'b0, 8'b01_00_00_00, 1'b0, 3'd0, 1'b1));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1));
    run("yellow_ok");

    // Yellow held only 2 cycles before red
    tbl.push_back(mk(8'b10_00_00_00, 1'b0, 8'b10_00_00_00, 1'b0, 3'd0, 1'b1));
    tbl.push_back(mk(8'b01_00_00_00, 1'b0, 8'b01_00_00_00, 1'b0, 3'd0, 1'b1));
    tbl.push_back(mk(8'b01_00_00_00, 1'b0, 8'b01_00_00_00, 1'b0, 3'd0, 1'b1));
`ifdef SCM_YELLOW_CHECK_EN
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b1, 3'd4, 1'b0));
    run("yellow_short");
    clear_and_recover();
`else
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1));
    run("yellow_short");
`endif

    // Persisting illegal code re-faults from RECOVER, also on the timeout cycle
    tbl.push_back(mk(8'b00_00_00_11, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0));
    tbl.push_back(mk(8'b00_00_00_11, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(8'b00_00_00_11, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0));
    tbl.push_back(mk(8'h00,         1'b1, 8'h00, 1'b0, 3'd0, 1'b0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0));
    tbl.push_back(mk(8'b00_00_00_11, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0));
    run("illegal");
    clear_and_recover();

    // Illegal plus double green together, then reset mid-flash (yellow phase)
    tbl.push_back(mk(8'b11_10_10_00, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h55, 1'b1, 3'd1, 1'b0));
    run("combo");
    rst_n = 1'b0;
    #1;
    check("async rst lamps", lamps_now(), 8'h00);
    check("async rst fault", {7'd0, fault}, 8'd0);
    check("async rst code",  {5'd0, fault_code}, 8'd0);
    check("async rst mon",   {7'd0, mon_active}, 8'd0);
    $display("async_reset: lamps=%b fault=%b code=%0d mon=%b",
             lamps_now(), fault, fault_code, mon_active);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/signal_conflict_monitor.md
SIGNAL_CONFLICT_MONITOR -- requirements
Module: signal_conflict_monitor

Interface
REQ-001 SHALL have parameter MIN_YEL_CYC, default 50000000, minimum cycles a yellow must last before turning red.
REQ-002 SHALL have parameter FLASH_CYC, default 25000000, half-period in cycles of the fault flash.
REQ-003 SHALL have parameter RECOVER_CYC, default 50000000, all-red hold in cycles before monitoring resumes.
REQ-004 SHALL have port clk  input  1  single clock; all flops on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports north_in, east_in, south_in, west_in  input  2 each  light codes from the traffic sequencer (00 red, 01 yellow, 10 green, 11 illegal).
REQ-007 SHALL have port clear_fault  input  1  single-cycle fault acknowledge.
REQ-008 SHALL have ports north_out, east_out, south_out, west_out  output  2 each  lamp drive codes, registered.
REQ-009 SHALL have port fault  output  1  high while in FAULT.
REQ-010 SHALL have port fault_code  output  3  first latched violation; 0 when none.
REQ-011 SHALL have port mon_active  output  1  high only in MONITOR.

Function
REQ-012 SHALL implement states MONITOR, FAULT, RECOVER.
REQ-013 MONITOR: outputs SHALL equal the inputs sampled on the previous edge (1-cycle latency).
REQ-014 SHALL evaluate violations combinationally each cycle in MONITOR and RECOVER, using current inputs and the previous-cycle input registers.
REQ-015 Violation codes, priority lowest first: 1 any input 11; 2 two or more inputs green; 3 an approach goes green to red directly; 4 an approach goes yellow to red after fewer than MIN_YEL_CYC cycles of yellow.
REQ-016 On any violation SHALL enter FAULT on the next edge and latch the highest-priority code; the offending pattern SHALL never reach the outputs.
REQ-017 Yellow to green and yellow to yellow SHALL NOT be checked by code 4.
REQ-018 Per-approach yellow counter SHALL clear on entry to yellow, count while yellow, and saturate at MIN_YEL_CYC.
REQ-019 FAULT: outputs SHALL alternate all-red and all-yellow every FLASH_CYC cycles, starting all-red; fault_code SHALL hold.
REQ-020 FAULT: new violations SHALL be ignored; clear_fault SHALL move to RECOVER and zero fault_code.
REQ-021 RECOVER: outputs all-red for RECOVER_CYC cycles, then MONITOR; a violation in RECOVER SHALL go to FAULT (takes precedence over the timeout in the same cycle).
REQ-022 clear_fault outside FAULT SHALL be ignored.
REQ-023 Previous-input registers and yellow counters SHALL update every cycle in all states.

Reset
REQ-024 Reset SHALL force state RECOVER, recover/flash counters 0, all outputs red (00), fault 0, fault_code 0, mon_active 0, previous-input registers red, yellow counters 0.
REQ-025 Reset asserted mid-FAULT or mid-RECOVER SHALL take effect immediately without waiting for a clock.

Configuration
REQ-026 With macro SCM_YELLOW_CHECK_EN defined, code-4 checking and the yellow counters SHALL be present.
REQ-027 Without SCM_YELLOW_CHECK_EN, the yellow counters SHALL be absent, code 4 SHALL never be raised, and MIN_YEL_CYC SHALL be unused.

Structure
REQ-028 Package signal_monitor_pkg SHALL hold the light encodings, the fault code constants and the state enum.
REQ-029 Sub-module scm_approach_check SHALL be instantiated four times and hold the per-approach previous-code register, yellow counter and code-3/code-4 flags.

Verification (MIN_YEL_CYC=4, FLASH_CYC=3, RECOVER_CYC=5)
REQ-030 Reset release with inputs all red: RECOVER for 5 cycles, then mon_active=1; input change appears on the outputs 1 cycle later.
REQ-031 In MONITOR drive north=10, east=10 -> next edge fault=1, fault_code=2, outputs 00; then yellow/red toggling every 3 cycles.
REQ-032 north 10 to 00 directly -> fault_code=3; with north 10, then 01 for 4 cycles, then 00 -> no fault.
REQ-033 north 01 for 2 cycles then 00 -> fault_code=4 when the macro is defined; no fault without it.
REQ-034 In FAULT pulse clear_fault while west=11 -> RECOVER, fault_code=0; the persisting 11 returns to FAULT with code 1 on the following edge.
REQ-035 Inputs 11 and double green in the same cycle -> fault_code=1; assert rst_n low mid-flash -> outputs 00 immediately.
